multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM that steps the RV32I datapath through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Uses one shared instruction/data memory through a req/ack handshake.
- Sits beside the combinational decode controller. That controller still supplies aluop, imm_type, brop and sel_wb. This block only gates the state-changing enables (pc, ir, rf, memory) and chooses the memory address source.
- Flags illegal opcodes and memory timeouts by parking in a TRAP state.

---
 rtl/multicycle_sequencer_if.sv | 12 +
 rtl/multicycle_sequencer.sv | 162 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory handshake between the sequencer and memory.
// Purely combinational bundle: no latency of its own.
// mem_req (with mem_we/sel_addr) is held by the master until the slave returns mem_ack.
interface multicycle_sequencer_if;
  logic mem_req;   // memory request, held until mem_ack
  logic mem_we;    // write request, meaningful only while mem_req=1
  logic sel_addr;  // address source: 0=pc, 1=alu result
  logic mem_ack;   // memory completed the current request this cycle

  modport master (output mem_req, output mem_we, output sel_addr, input mem_ack);
  modport slave  (input mem_req, input mem_we, input sel_addr, output mem_ack);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK, traps on bad opcode or memory timeout.
// Latency: ALU/JAL/JALR/store 4 cycles, load 5, branch 3 with zero-wait memory; strobes decode combinationally.
// Backpressure: stalls in FETCH/MEM until mem_ack; TIMEOUT cycles without ack parks in TRAP. Optional SEQ_PERF_EN adds perf counters.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               opcode,
  input  logic                     br_taken,
  multicycle_sequencer_if.master   mem,
  output logic                     ir_en,
  output logic                     pc_en,
  output logic                     sel_pc,
  output logic                     rf_en,
  output logic                     trap,
  output logic [2:0]               state
`ifdef SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  // Out-of-range parameters make the timeout compare or counters meaningless.
  if (TIMEOUT < 1 || TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("multicycle_sequencer: TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  state_t     state_q, state_d;
  logic [7:0] to_cnt;
  logic       to_hit;
  logic       waiting;

  assign to_hit = (to_cnt == TO_LAST);
  assign state  = state_q;

  // State register; reset parks in IDLE so all strobes (incl. mem_req) drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and strobe decode from current state, opcode and mem_ack.
  always_comb begin
    state_d      = state_q;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.sel_addr = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    sel_pc       = 1'b0;
    rf_en        = 1'b0;
    trap         = 1'b0;
    waiting      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
          OPC_BRANCH, OPC_JAL, OPC_JALR: state_d = S_EXECUTE;
          default:                       state_d = S_TRAP;
        endcase
      end
      S_EXECUTE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM;
          OPC_BRANCH: begin
            pc_en   = br_taken;
            sel_pc  = 1'b1;
            state_d = S_FETCH;
          end
          OPC_OP, OPC_OP_IMM: state_d = S_WB;
          OPC_JAL, OPC_JALR: begin
            pc_en   = 1'b1;
            sel_pc  = 1'b1;
            state_d = S_WB;
          end
          // opcode is held stable from DECODE, so this only guards a corrupted IR
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.sel_addr = 1'b1;
        mem.mem_we   = (opcode == OPC_STORE);
        if (mem.mem_ack) begin
          state_d = (opcode == OPC_STORE) ? S_FETCH : S_WB;
        end else if (to_hit) begin
          state_d = S_TRAP;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        rf_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  // Timeout counter: counts unacknowledged wait cycles, zero whenever a request starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       to_cnt <= 8'd0;
    else if (waiting) to_cnt <= to_cnt + 8'd1;
    else              to_cnt <= 8'd0;
  end

`ifdef SEQ_PERF_EN
  // Cycle counter: runs in every active state, frozen in IDLE and TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     cycle_cnt <= '0;
    else if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
  end

  // Retired-instruction counter: an instruction retires when control returns to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_cnt <= '0;
    end else if (state_d == S_FETCH &&
                 (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB)) begin
      instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction timelines built from the instruction class and
// memory wait counts, replayed cycle by cycle against the DUT; directed trap/timeout/reset steps.
// Build with +define+SEQ_PERF_EN to also check the performance counters.
module tb_multicycle_sequencer;
  localparam int unsigned TO = 4;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0;
  logic       ir_en, pc_en, sel_pc, rf_en, trap;
  logic [2:0] state;
`ifdef SEQ_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_sequencer_if mem_if ();

  multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .mem(mem_if.master),
    .ir_en(ir_en), .pc_en(pc_en), .sel_pc(sel_pc), .rf_en(rf_en), .trap(trap),
    .state(state)
`ifdef SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        br;
    logic [6:0]  opc;
    logic [10:0] exp;
  } cyc_t;

  cyc_t       q[$];
  logic [6:0] cur_opc;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [6:0] legal [7];

  // {state, mem_req, mem_we, sel_addr, ir_en, pc_en, sel_pc, rf_en, trap}
  function automatic logic [10:0] ev(input logic [2:0] st, input logic req, input logic we,
                                     input logic sa, input logic ir, input logic pc,
                                     input logic sp, input logic rf, input logic tr);
    return {st, req, we, sa, ir, pc, sp, rf, tr};
  endfunction

  function automatic logic [10:0] obs();
    return {state, mem_if.mem_req, mem_if.mem_we, mem_if.sel_addr, ir_en, pc_en, sel_pc, rf_en, trap};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic ack, input logic br, input logic [10:0] e);
    cyc_t c;
    c.ack = ack; c.br = br; c.opc = cur_opc; c.exp = e;
    q.push_back(c);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Timeline of one instruction: fetch waits, fetch ack, decode, then class-dependent tail.
  task automatic add_instr(input logic [6:0] opc, input int fw, input int mw, input logic br);
    logic st;
    cur_opc = opc;
    st = (opc == STORE);
    for (int i = 0; i < fw; i++) push(1'b0, 1'b0, ev(3'd1, 1, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'b0, ev(3'd1, 1, 0, 0, 1, 1, 0, 0, 0));
    push(rnd(), 1'b0, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
    if (opc == LOAD || opc == STORE) begin
      push(rnd(), 1'b0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < mw; i++) push(1'b0, 1'b0, ev(3'd4, 1, st, 1, 0, 0, 0, 0, 0));
      push(1'b1, 1'b0, ev(3'd4, 1, st, 1, 0, 0, 0, 0, 0));
      if (!st) push(rnd(), 1'b0, ev(3'd5, 0, 0, 0, 0, 0, 0, 1, 0));
    end else if (opc == BRANCH) begin
      push(rnd(), br, ev(3'd3, 0, 0, 0, 0, br, 1, 0, 0));
    end else if (opc == OP || opc == OP_IMM) begin
      push(rnd(), 1'b0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
      push(rnd(), 1'b0, ev(3'd5, 0, 0, 0, 0, 0, 0, 1, 0));
    end else if (opc == JAL || opc == JALR) begin
      push(rnd(), 1'b0, ev(3'd3, 0, 0, 0, 0, 1, 1, 0, 0));
      push(rnd(), 1'b0, ev(3'd5, 0, 0, 0, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic add_trap(input int n);
    for (int i = 0; i < n; i++) push(rnd(), rnd(), ev(3'd7, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  // Replay the queued cycles: drive just after the rising edge, compare on the falling edge.
  task automatic run_queue(input string tag);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      mem_if.mem_ack = c.ack;
      br_taken       = c.br;
      opcode         = c.opc;
      @(negedge clk);
      chk(tag, 32'(obs()), 32'(c.exp));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_if.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", 32'(obs()), 32'd0);
  endtask

  initial begin
    legal[0] = OP; legal[1] = OP_IMM; legal[2] = LOAD; legal[3] = STORE;
    legal[4] = BRANCH; legal[5] = JAL; legal[6] = JALR;
    mem_if.mem_ack = 1'b0;
    cur_opc = OP;

    // Reset state, then zero-wait R-type twice: 1,2,3,5,1,...
    do_reset();
`ifdef SEQ_PERF_EN
    chk("cycle_cnt_reset", cycle_cnt, 32'd0);
    chk("instret_cnt_reset", instret_cnt, 32'd0);
`endif
    add_instr(OP, 0, 0, 1'b0);
    add_instr(OP, 0, 0, 1'b0);
    run_queue("rtype");

    // Load with 2 fetch waits and immediate MEM ack; store; both branch outcomes; jumps; I-ALU.
    add_instr(LOAD, 2, 0, 1'b0);
    add_instr(STORE, 0, 1, 1'b0);
    add_instr(BRANCH, 0, 0, 1'b0);
    add_instr(BRANCH, 1, 0, 1'b1);
    add_instr(JAL, 0, 0, 1'b0);
    add_instr(JALR, 0, 0, 1'b0);
    add_instr(OP_IMM, 0, 0, 1'b0);
    // Ack on the last allowed cycle wins over the timeout, in FETCH and in MEM.
    add_instr(LOAD, TO - 1, TO - 1, 1'b0);
    add_instr(STORE, TO - 1, TO - 1, 1'b0);
    run_queue("directed");

    // Random instruction stream with random wait counts inside the timeout window.
    for (int i = 0; i < 60; i++) begin
      add_instr(legal[$urandom_range(0, 6)], $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), rnd());
    end
    run_queue("random");

    // Illegal opcode: DECODE then TRAP, held for 20 cycles whatever mem_ack does.
    add_instr(7'b0000000, 0, 0, 1'b0);
    add_trap(20);
    run_queue("illegal_trap");
    do_reset();

    // FETCH timeout: exactly TO waiting FETCH cycles, then TRAP.
    cur_opc = OP;
    for (int i = 0; i < TO; i++) push(1'b0, 1'b0, ev(3'd1, 1, 0, 0, 0, 0, 0, 0, 0));
    add_trap(3);
    run_queue("fetch_timeout");
    do_reset();

    // MEM timeout on a load.
    cur_opc = LOAD;
    push(1'b1, 1'b0, ev(3'd1, 1, 0, 0, 1, 1, 0, 0, 0));
    push(1'b0, 1'b0, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < TO; i++) push(1'b0, 1'b0, ev(3'd4, 1, 0, 1, 0, 0, 0, 0, 0));
    add_trap(3);
    run_queue("mem_timeout");
    do_reset();

    // Reset asserted mid MEM wait: mem_req and state drop immediately, nothing pulses.
    cur_opc = LOAD;
    push(1'b1, 1'b0, ev(3'd1, 1, 0, 0, 1, 1, 0, 0, 0));
    push(1'b0, 1'b0, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, ev(3'd4, 1, 0, 1, 0, 0, 0, 0, 0));
    run_queue("pre_mid_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", 32'(obs()), 32'd0);
    mem_if.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_held", 32'(obs()), 32'd0);
    do_reset();

`ifdef SEQ_PERF_EN
    // Ten zero-wait R-type instructions: 40 active cycles, 10 retirements.
    chk("cycle_cnt_cleared", cycle_cnt, 32'd0);
    chk("instret_cnt_cleared", instret_cnt, 32'd0);
    for (int i = 0; i < 10; i++) add_instr(OP, 0, 0, 1'b0);
    run_queue("perf_rtype");
    @(posedge clk);
    #1;
    chk("perf_state_fetch", 32'(state), 32'd1);
    chk("instret_cnt_10", instret_cnt, 32'd10);
    chk("cycle_cnt_40", cycle_cnt, 32'd40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case stimulus timing ever goes wrong.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
